// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus DTACK responder: state encoding,
// parameter defaults and counter widths.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FAST    = 3'd1,
    ST_MB_SYNC = 3'd2,
    ST_MB_WAIT = 3'd3,
    ST_ACK     = 3'd4,
    ST_BERR    = 3'd5
  } state_t;

  localparam int unsigned FAST_WAIT_DEFAULT  = 1;
  localparam int unsigned MB_TIMEOUT_DEFAULT = 64;

  // Fast wait covers 0..15, motherboard timeout covers 1..255.
  localparam int unsigned FAST_CNT_W = 4;
  localparam int unsigned TMO_CNT_W  = 8;

  typedef logic [FAST_CNT_W-1:0] fast_cnt_t;
  typedef logic [TMO_CNT_W-1:0]  tmo_cnt_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous bit.
module bit_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; both stages reset to the idle level of the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cpu_dtack_responder.sv
// Generates DTACK / BERR for the turbo CPU: fast-RAM cycles are acknowledged
// after a fixed wait, other cycles are forwarded to the motherboard bus in
// step with C7M and acknowledged from the motherboard DTACK or timed out.
module cpu_dtack_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned FAST_WAIT  = FAST_WAIT_DEFAULT,
  parameter int unsigned MB_TIMEOUT = MB_TIMEOUT_DEFAULT
) (
  input  logic CLKCPU,
  input  logic RESET,
  input  logic AS_CPU_n,
  input  logic FASTRAM_SEL,
  input  logic C7M,
  input  logic DTACK_MB_n,
  output logic AS_MB_n,
  output logic DTACK_CPU_n,
  output logic BERR_CPU_n,
  output logic BUSY
);

  state_t    state_q, state_d;
  fast_cnt_t fcnt_q, fcnt_d;
  tmo_cnt_t  tcnt_q, tcnt_d, tcnt_inc;
  logic      armed_q, armed_d;
  logic      as_mb_d, dtack_d, berr_d, busy_d;

  logic c7m_s, c7m_prev, dtack_mb_s;
  logic c7m_rise, c7m_fall;

  bit_sync #(.RESET_VAL(1'b1)) u_sync_c7m (
    .clk (CLKCPU),
    .rst (RESET),
    .d   (C7M),
    .q   (c7m_s)
  );

  bit_sync #(.RESET_VAL(1'b1)) u_sync_dtack (
    .clk (CLKCPU),
    .rst (RESET),
    .d   (DTACK_MB_n),
    .q   (dtack_mb_s)
  );

  // Previous-cycle copy of synchronised C7M for edge detection.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) c7m_prev <= 1'b1;
    else       c7m_prev <= c7m_s;
  end

  assign c7m_rise = c7m_s & ~c7m_prev;
  assign c7m_fall = ~c7m_s & c7m_prev;

  // Next state, counters and next registered output levels.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    tcnt_d   = tcnt_q;
    tcnt_inc = tcnt_q + TMO_CNT_W'(1);
    // Seeing the strobe high once re-arms the block after reset or a finished cycle.
    armed_d  = armed_q | AS_CPU_n;

    case (state_q)
      ST_IDLE: begin
        if (!AS_CPU_n && armed_q) begin
          armed_d = 1'b0;
          if (FASTRAM_SEL) begin
            state_d = ST_FAST;
            fcnt_d  = FAST_CNT_W'(FAST_WAIT);
          end else begin
            state_d = ST_MB_SYNC;
          end
        end
      end
      ST_FAST: begin
        if (AS_CPU_n)             state_d = ST_IDLE;
        else if (fcnt_q == '0)    state_d = ST_ACK;
        else                      fcnt_d  = fcnt_q - FAST_CNT_W'(1);
      end
      ST_MB_SYNC: begin
        if (AS_CPU_n) begin
          state_d = ST_IDLE;
        end else if (c7m_rise) begin
          state_d = ST_MB_WAIT;
          tcnt_d  = '0;
        end
      end
      ST_MB_WAIT: begin
        if (AS_CPU_n) begin
          state_d = ST_IDLE;
        end else if (c7m_fall) begin
          if (!dtack_mb_s) begin
            state_d = ST_ACK;
          end else begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc == TMO_CNT_W'(MB_TIMEOUT)) state_d = ST_BERR;
          end
        end
      end
      ST_ACK, ST_BERR: begin
        if (AS_CPU_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Motherboard strobe is held through ACK so a forwarded cycle stays
    // asserted until the CPU ends it; a fast cycle never drives it.
    as_mb_d = 1'b1;
    if (state_d == ST_MB_WAIT)  as_mb_d = 1'b0;
    else if (state_d == ST_ACK) as_mb_d = AS_MB_n;

    dtack_d = (state_d != ST_ACK);
    berr_d  = (state_d != ST_BERR);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      fcnt_q      <= '0;
      tcnt_q      <= '0;
      armed_q     <= 1'b0;
      AS_MB_n     <= 1'b1;
      DTACK_CPU_n <= 1'b1;
      BERR_CPU_n  <= 1'b1;
      BUSY        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      tcnt_q      <= tcnt_d;
      armed_q     <= armed_d;
      AS_MB_n     <= as_mb_d;
      DTACK_CPU_n <= dtack_d;
      BERR_CPU_n  <= berr_d;
      BUSY        <= busy_d;
    end
  end

endmodule

// File: tb/tb_cpu_dtack_responder.sv
// Bench for cpu_dtack_responder. One time unit stands for 100 ps:
// CLKCPU 50 MHz (period 200), C7M ~7.09 MHz (period 1410), edges never coincide.
module tb_cpu_dtack_responder;

  localparam int TB_FAST_WAIT  = 1;
  localparam int TB_MB_TIMEOUT = 4;
  localparam int CLK_HALF      = 100;
  localparam int C7M_HALF      = 705;
  localparam int C7M_OFS       = 23;

  localparam int P_IDLE   = 0;
  localparam int P_FAST   = 1;
  localparam int P_RISE   = 2;
  localparam int P_FALLS  = 3;
  localparam int P_ACK    = 4;
  localparam int P_ACK_MB = 5;
  localparam int P_BERR   = 6;

  logic CLKCPU, RESET, AS_CPU_n, FASTRAM_SEL, C7M, DTACK_MB_n;
  logic AS_MB_n, DTACK_CPU_n, BERR_CPU_n, BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_dtack_responder #(
    .FAST_WAIT  (TB_FAST_WAIT),
    .MB_TIMEOUT (TB_MB_TIMEOUT)
  ) dut (
    .CLKCPU      (CLKCPU),
    .RESET       (RESET),
    .AS_CPU_n    (AS_CPU_n),
    .FASTRAM_SEL (FASTRAM_SEL),
    .C7M         (C7M),
    .DTACK_MB_n  (DTACK_MB_n),
    .AS_MB_n     (AS_MB_n),
    .DTACK_CPU_n (DTACK_CPU_n),
    .BERR_CPU_n  (BERR_CPU_n),
    .BUSY        (BUSY)
  );

  initial begin
    CLKCPU = 1'b0;
    forever #CLK_HALF CLKCPU = ~CLKCPU;
  end

  initial begin
    C7M = 1'b0;
    #C7M_OFS;
    forever #C7M_HALF C7M = ~C7M;
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_le(input string name, input longint act, input longint max);
    n_checks++;
    if (act > max) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected at most %0d (t=%0t)", name, act, max, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Phase of the current CPU cycle; the synchronisers are modelled as a
  // two-sample delay on the raw inputs seen at each rising CLKCPU edge.
  int   phase, edge_no, ack_edge, falls;
  bit   armed;
  bit   h1, h2, h3, d1, d2;
  logic e_asmb, e_dtack, e_berr, e_busy;

  task automatic model_outputs();
    e_busy  = (phase != P_IDLE);
    e_dtack = !(phase == P_ACK || phase == P_ACK_MB);
    e_berr  = (phase != P_BERR);
    e_asmb  = !(phase == P_FALLS || phase == P_ACK_MB);
  endtask

  task automatic model_reset();
    phase = P_IDLE; edge_no = 0; ack_edge = 0; falls = 0; armed = 1'b0;
    h1 = 1'b1; h2 = 1'b1; h3 = 1'b1; d1 = 1'b1; d2 = 1'b1;
    model_outputs();
  endtask

  task automatic model_step();
    bit as_hi, rise, fall;
    as_hi = AS_CPU_n;
    rise  = h2 && !h3;
    fall  = !h2 && h3;
    edge_no++;
    if (phase == P_IDLE) begin
      if (!as_hi && armed) begin
        armed = 1'b0;
        if (FASTRAM_SEL) begin
          phase    = P_FAST;
          ack_edge = edge_no + TB_FAST_WAIT + 1;
        end else begin
          phase = P_RISE;
        end
      end
    end else if (as_hi) begin
      phase = P_IDLE;
    end else if (phase == P_FAST) begin
      if (edge_no == ack_edge) phase = P_ACK;
    end else if (phase == P_RISE) begin
      if (rise) begin phase = P_FALLS; falls = 0; end
    end else if (phase == P_FALLS && fall) begin
      if (!d2) phase = P_ACK_MB;
      else begin
        falls++;
        if (falls == TB_MB_TIMEOUT) phase = P_BERR;
      end
    end
    if (as_hi) armed = 1'b1;
    model_outputs();
    h3 = h2; h2 = h1; h1 = C7M;
    d2 = d1; d1 = DTACK_MB_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLKCPU or posedge RESET);
      if (RESET) model_reset();
      else       model_step();
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  int dt_pulses = 0, berr_pulses = 0;
  bit dt_prev = 1'b1, berr_prev = 1'b1;

  initial begin
    forever begin
      @(negedge CLKCPU);
      check_bit("as_mb_n",     AS_MB_n,     e_asmb);
      check_bit("dtack_cpu_n", DTACK_CPU_n, e_dtack);
      check_bit("berr_cpu_n",  BERR_CPU_n,  e_berr);
      check_bit("busy",        BUSY,        e_busy);
      check_bit("dtack_berr_exclusive", DTACK_CPU_n | BERR_CPU_n, 1'b1);
      if (dt_prev && !DTACK_CPU_n)  dt_pulses++;
      if (berr_prev && !BERR_CPU_n) berr_pulses++;
      dt_prev   = DTACK_CPU_n;
      berr_prev = BERR_CPU_n;
    end
  end

  // ---------------- motherboard responder ----------------
  int     mb_delay = 99;
  int     mb_cnt   = 0;
  int     mb_falls = 0;
  longint last_fall = 0;

  initial begin
    DTACK_MB_n = 1'b1;
    forever begin
      @(posedge C7M);
      if (!AS_MB_n) begin
        mb_cnt++;
        if (mb_cnt >= mb_delay) DTACK_MB_n = 1'b0;
      end else begin
        mb_cnt     = 0;
        DTACK_MB_n = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge C7M);
      last_fall = $time;
      if (!AS_MB_n) mb_falls++;
    end
  end

  initial begin
    #(2 * CLK_HALF * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge CLKCPU);
    #1;
  endtask

  task automatic wait_low(input string name, ref logic sig, input int budget, output int cyc);
    cyc = 0;
    while (sig !== 1'b0 && cyc < budget) begin
      step();
      cyc++;
    end
    check_bit(name, sig, 1'b0);
  endtask

  task automatic do_cycle(input bit fast, input int delay, input int abort_after, input int hold);
    int cyc;
    dt_pulses   = 0;
    berr_pulses = 0;
    mb_delay    = delay;
    AS_CPU_n    = 1'b0;
    FASTRAM_SEL = fast;
    if (abort_after > 0) begin
      repeat (abort_after) begin
        step();
        FASTRAM_SEL = 1'($urandom_range(0, 1));
      end
      AS_CPU_n = 1'b1;
      step();
      check_le("abort_at_most_one_dtack", dt_pulses, 1);
    end else begin
      cyc = 0;
      while (DTACK_CPU_n && BERR_CPU_n && cyc < 400) begin
        step();
        FASTRAM_SEL = 1'($urandom_range(0, 1));
        cyc++;
      end
      check_bit("cycle_terminated", DTACK_CPU_n & BERR_CPU_n, 1'b0);
      repeat (hold) step();
      AS_CPU_n = 1'b1;
      step();
      check_int("one_termination_per_as", dt_pulses + berr_pulses, 1);
    end
    repeat ($urandom_range(0, 3)) step();
  endtask

  initial begin
    int cyc;
    RESET       = 1'b1;
    AS_CPU_n    = 1'b0;
    FASTRAM_SEL = 1'b0;

    repeat (3) step();
    check_bit("reset_as_mb_n",     AS_MB_n,     1'b1);
    check_bit("reset_dtack_cpu_n", DTACK_CPU_n, 1'b1);
    check_bit("reset_berr_cpu_n",  BERR_CPU_n,  1'b1);
    check_bit("reset_busy",        BUSY,        1'b0);
    RESET = 1'b0;

    // Strobe low straight out of reset must not start a cycle.
    repeat (4) step();
    check_bit("no_start_before_as_high", BUSY, 1'b0);

    // Fast cycle with FAST_WAIT=1: DTACK on the third edge.
    AS_CPU_n = 1'b1;
    step();
    AS_CPU_n = 1'b0; FASTRAM_SEL = 1'b1;
    step();
    check_bit("fast_edge1_dtack", DTACK_CPU_n, 1'b1);
    check_bit("fast_edge1_busy",  BUSY,        1'b1);
    FASTRAM_SEL = 1'b0;
    step();
    check_bit("fast_edge2_dtack", DTACK_CPU_n, 1'b1);
    step();
    check_bit("fast_edge3_dtack", DTACK_CPU_n, 1'b0);
    check_bit("fast_as_mb_idle",  AS_MB_n,     1'b1);
    AS_CPU_n = 1'b1;
    step();
    check_bit("fast_release_dtack", DTACK_CPU_n, 1'b1);
    check_bit("fast_release_busy",  BUSY,        1'b0);

    // Motherboard cycle, DTACK_MB_n after two C7M periods.
    mb_delay = 2; FASTRAM_SEL = 1'b0; AS_CPU_n = 1'b0;
    wait_low("mb_as_mb_asserted", AS_MB_n, 40, cyc);
    check_le("mb_as_mb_latency_cycles", cyc, 11);
    wait_low("mb_dtack_asserted", DTACK_CPU_n, 400, cyc);
    check_le("mb_dtack_after_fall", ($time - 1 - CLK_HALF) - last_fall, 6 * CLK_HALF);
    check_bit("mb_ack_as_mb_held", AS_MB_n, 1'b0);
    AS_CPU_n = 1'b1;
    step();
    check_bit("mb_release_dtack", DTACK_CPU_n, 1'b1);
    check_bit("mb_release_as_mb", AS_MB_n,     1'b1);

    // Timeout: no motherboard DTACK, bus error after the 4th C7M fall.
    mb_delay = 99; mb_falls = 0; AS_CPU_n = 1'b0;
    wait_low("tmo_berr_asserted", BERR_CPU_n, 400, cyc);
    check_int("tmo_c7m_falls", mb_falls, 4);
    check_bit("tmo_dtack_high", DTACK_CPU_n, 1'b1);
    check_bit("tmo_as_mb_high", AS_MB_n,     1'b1);
    AS_CPU_n = 1'b1;
    step();
    check_bit("tmo_release_berr", BERR_CPU_n, 1'b1);
    check_bit("tmo_release_busy", BUSY,       1'b0);

    // Abort while waiting on the motherboard.
    dt_pulses = 0; AS_CPU_n = 1'b0;
    wait_low("abort_as_mb_asserted", AS_MB_n, 40, cyc);
    step();
    AS_CPU_n = 1'b1;
    step();
    check_bit("abort_as_mb_high", AS_MB_n,     1'b1);
    check_bit("abort_busy_low",   BUSY,        1'b0);
    check_int("abort_no_dtack",   dt_pulses,   0);

    // Reset pulse during MB_WAIT releases AS_MB_n without a clock edge.
    AS_CPU_n = 1'b0;
    wait_low("rst_as_mb_asserted", AS_MB_n, 40, cyc);
    #29 RESET = 1'b1;
    #10;
    check_bit("rst_async_as_mb_high", AS_MB_n, 1'b1);
    check_bit("rst_async_busy_low",   BUSY,    1'b0);
    #20 RESET = 1'b0;
    repeat (5) step();
    check_bit("rst_no_restart_while_as_low", BUSY, 1'b0);
    AS_CPU_n = 1'b1;
    step();
    AS_CPU_n = 1'b0; FASTRAM_SEL = 1'b1;
    wait_low("rst_then_fast_dtack", DTACK_CPU_n, 20, cyc);
    check_int("rst_then_fast_latency", cyc, TB_FAST_WAIT + 2);
    AS_CPU_n = 1'b1;
    step();

    // Randomised back-to-back fast and motherboard cycles.
    for (int i = 0; i < 60; i++) begin
      bit fast;
      int abort_after;
      fast        = 1'($urandom_range(0, 1));
      abort_after = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0;
      do_cycle(fast, int'($urandom_range(1, 6)), abort_after, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_dtack_responder.md
CPU_DTACK_RESPONDER -- requirements
Module: cpu_dtack_responder

Interface
REQ-001 SHALL have parameter FAST_WAIT, default 1, meaning CLKCPU wait cycles before DTACK for fast-RAM cycles (0..15).
REQ-002 SHALL have parameter MB_TIMEOUT, default 64, meaning C7M falling edges without motherboard DTACK before bus error (1..255).
REQ-003 SHALL have port CLKCPU  in  1  turbo CPU clock, the only clock; all flops on its rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port AS_CPU_n  in  1  CPU address strobe; CLKCPU-synchronous, no synchroniser.
REQ-006 SHALL have port FASTRAM_SEL  in  1  decoded fast-RAM hit; valid whenever AS_CPU_n=0.
REQ-007 SHALL have port C7M  in  1  motherboard 7 MHz clock, sampled as data.
REQ-008 SHALL have port DTACK_MB_n  in  1  motherboard DTACK, asynchronous.
REQ-009 SHALL have port AS_MB_n  out  1  motherboard address strobe, registered.
REQ-010 SHALL have port DTACK_CPU_n  out  1  DTACK to CPU, registered.
REQ-011 SHALL have port BERR_CPU_n  out  1  bus error to CPU, registered.
REQ-012 SHALL have port BUSY  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass C7M and DTACK_MB_n through 2-flop synchronisers; C7M rise/fall events SHALL be detected from the synchronised value and its previous-cycle copy.
REQ-014 SHALL implement states IDLE, FAST, MB_SYNC, MB_WAIT, ACK, BERR.
REQ-015 IDLE: AS_CPU_n=0 and FASTRAM_SEL=1 -> FAST with wait counter loaded with FAST_WAIT; AS_CPU_n=0 and FASTRAM_SEL=0 -> MB_SYNC.
REQ-016 FAST: counter decrements each cycle; at 0 -> ACK; FAST_WAIT=0 SHALL give DTACK_CPU_n low on the second CLKCPU edge after AS_CPU_n is sampled low.
REQ-017 MB_SYNC: on a detected C7M rise, AS_MB_n SHALL go low and state -> MB_WAIT with timeout counter cleared.
REQ-018 MB_WAIT: on each detected C7M fall, synchronised DTACK_MB_n=0 -> ACK; otherwise the timeout counter increments; when it reaches MB_TIMEOUT -> BERR.
REQ-019 ACK: DTACK_CPU_n=0; AS_MB_n keeps its value; AS_CPU_n sampled high -> IDLE, releasing DTACK_CPU_n and AS_MB_n on that same edge.
REQ-020 BERR: BERR_CPU_n=0, AS_MB_n=1; AS_CPU_n sampled high -> IDLE.
REQ-021 AS_CPU_n sampled high in FAST, MB_SYNC or MB_WAIT (aborted cycle) SHALL force IDLE with all outputs high on that edge.
REQ-022 DTACK_CPU_n and BERR_CPU_n SHALL never be low simultaneously.
REQ-023 A new cycle SHALL NOT start until AS_CPU_n has been sampled high at least once after ACK or BERR.
REQ-024 FASTRAM_SEL SHALL be sampled only in IDLE; later changes are ignored.

Reset
REQ-025 RESET high SHALL asynchronously force state IDLE, counters 0, synchroniser flops 1, AS_MB_n=1, DTACK_CPU_n=1, BERR_CPU_n=1, BUSY=0.
REQ-026 RESET asserted mid-cycle SHALL release AS_MB_n immediately; after release, the block SHALL wait for AS_CPU_n high before accepting a cycle.

Structure
REQ-027 State encoding, FAST_WAIT/MB_TIMEOUT defaults and counter widths SHALL live in a shared package, cpu_bus_pkg.
REQ-028 The 2-flop synchroniser SHALL be one sub-module, bit_sync, with reset value as parameter, instantiated twice.

Verification
REQ-029 FAST_WAIT=1, AS_CPU_n low with FASTRAM_SEL=1 -> DTACK_CPU_n low 3 edges later; AS_CPU_n high -> DTACK high next edge.
REQ-030 CLKCPU 50 MHz, C7M 7.09 MHz, FASTRAM_SEL=0, DTACK_MB_n low after 2 C7M periods -> AS_MB_n low within 1 C7M period + 3 CLKCPU, then DTACK_CPU_n low within 3 CLKCPU of the following C7M fall.
REQ-031 MB_TIMEOUT=4, DTACK_MB_n held high -> BERR_CPU_n low after the 4th C7M fall; DTACK_CPU_n stays high; AS_MB_n high.
REQ-032 AS_CPU_n released in MB_WAIT -> AS_MB_n high and BUSY=0 next edge, no DTACK_CPU_n pulse.
REQ-033 RESET pulse in MB_WAIT -> AS_MB_n high without clock edge; no new cycle until AS_CPU_n seen high.
REQ-034 Randomised back-to-back fast/motherboard cycles -> DTACK_CPU_n and BERR_CPU_n never low together; one DTACK per AS_CPU_n assertion.
